// File: rtl/ps2_key_event_pkg.sv
// Shared types and scan-code constants for the PS/2 set-2 key event decoder.
package ps2_key_event_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } state_e;

    localparam logic [7:0] SC_EXT     = 8'hE0;
    localparam logic [7:0] SC_BRK     = 8'hF0;
    localparam logic [7:0] SC_LSHIFT  = 8'h12;
    localparam logic [7:0] SC_RSHIFT  = 8'h59;
    localparam logic [7:0] ASCII_NONE = 8'h20;

    // Keyboard housekeeping bytes (overrun, BAT ok, ack, resend, error) carry no key.
    function automatic logic is_ignore_byte(input logic [7:0] b);
        return (b == 8'h00) || (b == 8'hAA) || (b == 8'hFA) ||
               (b == 8'hFE) || (b == 8'hFF);
    endfunction

endpackage

// File: rtl/ps2_key_event_if.sv
// Byte input and key event output bundle between receiver, decoder and display stage.
interface ps2_key_event_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       key_valid;
    logic [7:0] key_code;
    logic       key_ext;
    logic [7:0] key_ascii;
    logic       key_down;
    logic [3:0] rel_tens;
    logic [3:0] rel_ones;

    modport master (
        output rx_data, rx_valid,
        input  key_valid, key_code, key_ext, key_ascii, key_down, rel_tens, rel_ones
    );

    modport slave (
        input  rx_data, rx_valid,
        output key_valid, key_code, key_ext, key_ascii, key_down, rel_tens, rel_ones
    );
endinterface

// File: rtl/ps2_key_event_ascii_lut.sv
// Combinational set-2 scan code to ASCII map with shift-aware letters.
module ps2_ascii_lut
    import ps2_key_event_pkg::*;
(
    input  logic [7:0] code,
    input  logic       ext,
    input  logic       shift,
    output logic [7:0] ascii
);
    logic [7:0] letter;

    always_comb begin
        letter = 8'h00;
        case (code)
            8'h1C: letter = 8'h61;  8'h32: letter = 8'h62;  8'h21: letter = 8'h63;
            8'h23: letter = 8'h64;  8'h24: letter = 8'h65;  8'h2B: letter = 8'h66;
            8'h34: letter = 8'h67;  8'h33: letter = 8'h68;  8'h43: letter = 8'h69;
            8'h3B: letter = 8'h6A;  8'h42: letter = 8'h6B;  8'h4B: letter = 8'h6C;
            8'h3A: letter = 8'h6D;  8'h31: letter = 8'h6E;  8'h44: letter = 8'h6F;
            8'h4D: letter = 8'h70;  8'h15: letter = 8'h71;  8'h2D: letter = 8'h72;
            8'h1B: letter = 8'h73;  8'h2C: letter = 8'h74;  8'h3C: letter = 8'h75;
            8'h2A: letter = 8'h76;  8'h1D: letter = 8'h77;  8'h22: letter = 8'h78;
            8'h35: letter = 8'h79;  8'h1A: letter = 8'h7A;
            default: letter = 8'h00;
        endcase
    end

    always_comb begin
        ascii = ASCII_NONE;
        if (!ext) begin
            if (letter != 8'h00) begin
                // Upper case sits exactly 0x20 below lower case.
                ascii = shift ? (letter - 8'h20) : letter;
            end else begin
                case (code)
                    8'h45: ascii = 8'h30;  8'h16: ascii = 8'h31;  8'h1E: ascii = 8'h32;
                    8'h26: ascii = 8'h33;  8'h25: ascii = 8'h34;  8'h2E: ascii = 8'h35;
                    8'h36: ascii = 8'h36;  8'h3D: ascii = 8'h37;  8'h3E: ascii = 8'h38;
                    8'h46: ascii = 8'h39;  8'h29: ascii = 8'h20;  8'h5A: ascii = 8'h0D;
                    default: ascii = ASCII_NONE;
                endcase
            end
        end
    end
endmodule

// File: rtl/ps2_key_event.sv
// Set-2 make/break/extended decoder producing key-press events, held-key flag and BCD release count.
module ps2_key_event
    import ps2_key_event_pkg::*;
#(
    parameter bit SUPPRESS_REPEAT = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    ps2_key_event_if.slave bus
);
    state_e     state_q, state_d;
    logic       lshift_q, lshift_d, rshift_q, rshift_d;
    logic       key_valid_q, key_valid_d;
    logic [7:0] key_code_q, key_code_d;
    logic       key_ext_q, key_ext_d;
    logic [7:0] key_ascii_q, key_ascii_d;
    logic       key_down_q, key_down_d;
    logic [7:0] held_code_q, held_code_d;
    logic       held_ext_q, held_ext_d;
    logic [3:0] tens_q, tens_d, ones_q, ones_d;

    logic       is_make, is_break, act_ext, is_shift, held_match;
    logic       rx_e0, rx_f0;
    logic [7:0] lut_ascii;

    assign rx_e0 = (bus.rx_data == SC_EXT);
    assign rx_f0 = (bus.rx_data == SC_BRK);

    ps2_ascii_lut u_lut (
        .code  (bus.rx_data),
        .ext   (act_ext),
        .shift (lshift_q | rshift_q),
        .ascii (lut_ascii)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            lshift_q    <= 1'b0;
            rshift_q    <= 1'b0;
            key_valid_q <= 1'b0;
            key_code_q  <= 8'h00;
            key_ext_q   <= 1'b0;
            key_ascii_q <= 8'h00;
            key_down_q  <= 1'b0;
            held_code_q <= 8'h00;
            held_ext_q  <= 1'b0;
            tens_q      <= 4'd0;
            ones_q      <= 4'd0;
        end else begin
            state_q     <= state_d;
            lshift_q    <= lshift_d;
            rshift_q    <= rshift_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            key_ext_q   <= key_ext_d;
            key_ascii_q <= key_ascii_d;
            key_down_q  <= key_down_d;
            held_code_q <= held_code_d;
            held_ext_q  <= held_ext_d;
            tens_q      <= tens_d;
            ones_q      <= ones_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.rx_valid) begin
            case (state_q)
                ST_IDLE:  state_d = rx_e0 ? ST_EXT : (rx_f0 ? ST_BRK : ST_IDLE);
                ST_EXT:   state_d = rx_f0 ? ST_EXT_BRK : (rx_e0 ? ST_EXT : ST_IDLE);
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // A prefix byte arriving after F0 is malformed and simply discarded.
    always_comb begin
        is_make  = 1'b0;
        is_break = 1'b0;
        act_ext  = 1'b0;
        if (bus.rx_valid) begin
            case (state_q)
                ST_IDLE:    is_make = !(rx_e0 || rx_f0 || is_ignore_byte(bus.rx_data));
                ST_EXT:     begin is_make  = !(rx_e0 || rx_f0); act_ext = 1'b1; end
                ST_BRK:     is_break = !(rx_e0 || rx_f0);
                ST_EXT_BRK: begin is_break = !(rx_e0 || rx_f0); act_ext = 1'b1; end
                default:    is_make = 1'b0;
            endcase
        end
    end

    assign is_shift   = !act_ext && ((bus.rx_data == SC_LSHIFT) || (bus.rx_data == SC_RSHIFT));
    assign held_match = ({act_ext, bus.rx_data} == {held_ext_q, held_code_q});

    always_comb begin
        lshift_d    = lshift_q;
        rshift_d    = rshift_q;
        key_valid_d = 1'b0;
        key_code_d  = key_code_q;
        key_ext_d   = key_ext_q;
        key_ascii_d = key_ascii_q;
        key_down_d  = key_down_q;
        held_code_d = held_code_q;
        held_ext_d  = held_ext_q;
        tens_d      = tens_q;
        ones_d      = ones_q;
        if (is_make) begin
            if (is_shift) begin
                if (bus.rx_data == SC_LSHIFT) lshift_d = 1'b1;
                else                          rshift_d = 1'b1;
            end else if (!(SUPPRESS_REPEAT && key_down_q && held_match)) begin
                key_valid_d = 1'b1;
                key_code_d  = bus.rx_data;
                key_ext_d   = act_ext;
                key_ascii_d = lut_ascii;
                key_down_d  = 1'b1;
                held_code_d = bus.rx_data;
                held_ext_d  = act_ext;
            end
        end else if (is_break) begin
            if (is_shift) begin
                if (bus.rx_data == SC_LSHIFT) lshift_d = 1'b0;
                else                          rshift_d = 1'b0;
            end else if (held_match) begin
                key_down_d = 1'b0;
                if (ones_q == 4'd9) begin
                    ones_d = 4'd0;
                    tens_d = (tens_q == 4'd9) ? 4'd0 : tens_q + 4'd1;
                end else begin
                    ones_d = ones_q + 4'd1;
                end
            end
        end
    end

    assign bus.key_valid = key_valid_q;
    assign bus.key_code  = key_code_q;
    assign bus.key_ext   = key_ext_q;
    assign bus.key_ascii = key_ascii_q;
    assign bus.key_down  = key_down_q;
    assign bus.rel_tens  = tens_q;
    assign bus.rel_ones  = ones_q;
endmodule

// File: tb/tb_ps2_key_event.sv
// Directed bench for ps2_key_event: one instance with repeat suppression, one without.
module tb_ps2_key_event;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    int   pulses_a = 0, pulses_b = 0;
    int   width_err = 0;
    int   ascii_err = 0;
    logic prev_kv = 1'b0;

    always #5 clk = ~clk;

    ps2_key_event_if bus_a ();
    ps2_key_event_if bus_b ();

    ps2_key_event #(.SUPPRESS_REPEAT(1'b1)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    ps2_key_event #(.SUPPRESS_REPEAT(1'b0)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

    // Pulse counting and width tracking, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus_a.key_valid) begin
            pulses_a++;
            if (bus_a.key_ascii !== 8'h30 && bus_a.key_code === 8'h45) ascii_err++;
        end
        if (bus_b.key_valid) pulses_b++;
        if (bus_a.key_valid && prev_kv) width_err++;
        prev_kv = bus_a.key_valid;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [7:0] b, input logic v);
        bus_a.rx_data = b; bus_a.rx_valid = v;
        bus_b.rx_data = b; bus_b.rx_valid = v;
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk); drive(b, 1'b1);
        @(negedge clk); drive(8'h00, 1'b0);
        @(negedge clk);
    endtask

    function automatic logic [7:0] rel(input logic [3:0] t, input logic [3:0] o);
        return {t, o};
    endfunction

    int p0, p0b;

    initial begin
        drive(8'h00, 1'b0);
        repeat (3) @(negedge clk);
        chk("rst_valid", bus_a.key_valid, 0);
        chk("rst_code",  bus_a.key_code,  8'h00);
        chk("rst_ascii", bus_a.key_ascii, 8'h00);
        chk("rst_down",  bus_a.key_down,  0);
        chk("rst_rel",   rel(bus_a.rel_tens, bus_a.rel_ones), 8'h00);
        reset = 1'b1;

        // 1: plain press and release of 'a', with latency check
        @(negedge clk); drive(8'h1C, 1'b1);
        @(negedge clk); drive(8'h00, 1'b0);
        chk("t1_latency", bus_a.key_valid, 1);
        @(negedge clk);
        chk("t1_width",   bus_a.key_valid, 0);
        chk("t1_code",    bus_a.key_code,  8'h1C);
        chk("t1_ascii",   bus_a.key_ascii, 8'h61);
        chk("t1_ext",     bus_a.key_ext,   0);
        chk("t1_down",    bus_a.key_down,  1);
        send(8'hF0); send(8'h1C);
        chk("t1_up",      bus_a.key_down,  0);
        chk("t1_rel",     rel(bus_a.rel_tens, bus_a.rel_ones), 8'h01);
        chk("t1_pulses",  pulses_a, 1);

        // 2: shifted 'A', then shift released
        p0 = pulses_a;
        send(8'h12);
        chk("t2_shift_noevt", pulses_a, p0);
        send(8'h1C);
        chk("t2_pulses",  pulses_a, p0 + 1);
        chk("t2_ascii",   bus_a.key_ascii, 8'h41);
        send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12);
        chk("t2_rel",     rel(bus_a.rel_tens, bus_a.rel_ones), 8'h02);
        send(8'h1C);
        chk("t2_unshift", bus_a.key_ascii, 8'h61);
        send(8'hF0); send(8'h1C);
        chk("t2_rel2",    rel(bus_a.rel_tens, bus_a.rel_ones), 8'h03);

        // 3: typematic repeat
        p0 = pulses_a; p0b = pulses_b;
        repeat (5) send(8'h1C);
        send(8'hF0); send(8'h1C);
        chk("t3_suppr",   pulses_a, p0 + 1);
        chk("t3_nosuppr", pulses_b, p0b + 5);
        chk("t3_rel_a",   rel(bus_a.rel_tens, bus_a.rel_ones), 8'h04);
        chk("t3_rel_b",   rel(bus_b.rel_tens, bus_b.rel_ones), 8'h04);

        // 4: extended key
        p0 = pulses_a;
        send(8'hE0); send(8'h75);
        chk("t4_pulses",  pulses_a, p0 + 1);
        chk("t4_code",    bus_a.key_code,  8'h75);
        chk("t4_ext",     bus_a.key_ext,   1);
        chk("t4_ascii",   bus_a.key_ascii, 8'h20);
        send(8'hE0); send(8'hF0); send(8'h75);
        chk("t4_up",      bus_a.key_down,  0);
        chk("t4_rel",     rel(bus_a.rel_tens, bus_a.rel_ones), 8'h05);

        // 5: release counter carry and wrap (starting from 05)
        p0 = pulses_a; ascii_err = 0;
        for (int i = 1; i <= 95; i++) begin
            send(8'h45); send(8'hF0); send(8'h45);
            if (i == 4)  chk("t5_rel09", rel(bus_a.rel_tens, bus_a.rel_ones), 8'h09);
            if (i == 5)  chk("t5_rel10", rel(bus_a.rel_tens, bus_a.rel_ones), 8'h10);
            if (i == 94) chk("t5_rel99", rel(bus_a.rel_tens, bus_a.rel_ones), 8'h99);
        end
        chk("t5_rel00",   rel(bus_a.rel_tens, bus_a.rel_ones), 8'h00);
        chk("t5_pulses",  pulses_a, p0 + 95);
        chk("t5_ascii",   ascii_err, 0);

        // 6: reset clears a pending break prefix
        send(8'hF0);
        @(negedge clk); reset = 1'b0; drive(8'h1C, 1'b1);
        @(negedge clk); drive(8'h00, 1'b0);
        chk("t6_rst_valid", bus_a.key_valid, 0);
        chk("t6_rst_code",  bus_a.key_code,  8'h00);
        chk("t6_rst_ascii", bus_a.key_ascii, 8'h00);
        chk("t6_rst_rel",   rel(bus_a.rel_tens, bus_a.rel_ones), 8'h00);
        reset = 1'b1;
        p0 = pulses_a;
        send(8'h1C);
        chk("t6_make",    pulses_a, p0 + 1);
        chk("t6_code",    bus_a.key_code,  8'h1C);
        chk("t6_down",    bus_a.key_down,  1);
        send(8'hFA); send(8'hAA);
        chk("t6_ignore",  pulses_a, p0 + 1);

        // New key while one is held: old release is not counted
        send(8'h32);
        chk("t7_pulses",  pulses_a, p0 + 2);
        chk("t7_ascii",   bus_a.key_ascii, 8'h62);
        send(8'hF0); send(8'h1C);
        chk("t7_norel",   rel(bus_a.rel_tens, bus_a.rel_ones), 8'h00);
        chk("t7_held",    bus_a.key_down, 1);
        send(8'hF0); send(8'h32);
        chk("t7_rel",     rel(bus_a.rel_tens, bus_a.rel_ones), 8'h01);
        chk("width",      width_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
